// File: rtl/game_flow_ctrl.sv
// Game flow controller: countdown, logo scroll, player slide-in, play with
// lane movement, coin scoring, hazard hits with invulnerability, game over.
// All state advances on frame_tick; hit pulses between ticks are latched.
module game_flow_ctrl #(
    parameter int NUM_LANES     = 3,
    parameter int LANE_PITCH    = 100,
    parameter int NUM_COIN_CH   = 3,
    parameter int NUM_HAZ_CH    = 4,
    parameter int SCORE_WIDTH   = 16,
    parameter int LIVES         = 3,
    parameter int INVULN_FRAMES = 60,
    parameter int COUNTDOWN     = 5,
    parameter int LOGO_STEP     = 30,
    parameter int LOGO_END      = 640,
    parameter int PLAYER_START  = 180,
    parameter int PLAYER_END    = 50,
    parameter int PLAYER_STEP   = 20
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           frame_tick,
    input  logic                           btn_left,
    input  logic                           btn_right,
    input  logic [NUM_COIN_CH-1:0]         coin_hit,
    input  logic [NUM_HAZ_CH-1:0]          haz_hit,
    output logic [2:0]                     state,
    output logic [11:0]                    logo_voffset,
    output logic [11:0]                    player_voffset,
    output logic [11:0]                    player_hoffset,
    output logic [$clog2(NUM_LANES)-1:0]   player_lane,
    output logic [SCORE_WIDTH-1:0]         score,
    output logic [2:0]                     lives,
    output logic                           spawn_en,
    output logic                           game_over
);
    localparam int LANE_W = $clog2(NUM_LANES);
    localparam int CNT_W  = $clog2(COUNTDOWN + 2);
    localparam int INV_W  = $clog2(INVULN_FRAMES + 2);

    localparam logic [LANE_W-1:0]   LANE_MID   = LANE_W'(NUM_LANES / 2);
    localparam logic [LANE_W-1:0]   LANE_MAX   = LANE_W'(NUM_LANES - 1);
    localparam logic signed [11:0]  LOGO_END_W = 12'(LOGO_END);
    localparam logic signed [11:0]  LOGO_STP_W = 12'(LOGO_STEP);
    localparam logic signed [11:0]  PL_START_W = 12'(PLAYER_START);
    localparam logic signed [11:0]  PL_END_W   = 12'(PLAYER_END);
    localparam logic signed [11:0]  PL_STEP_W  = 12'(PLAYER_STEP);

    typedef enum logic [2:0] {
        ST_COUNT = 3'd0,
        ST_LOGO  = 3'd1,
        ST_INTRO = 3'd2,
        ST_PLAY  = 3'd3,
        ST_HIT   = 3'd4,
        ST_OVER  = 3'd5
    } state_t;

    state_t                   state_reg, state_next;
    logic [CNT_W-1:0]         cnt_reg, cnt_next;
    logic signed [11:0]       logo_reg, logo_next;
    logic signed [11:0]       pv_reg, pv_next;
    logic [11:0]              hoff_reg, hoff_next;
    logic [LANE_W-1:0]        lane_reg, lane_next, lane_mv;
    logic [SCORE_WIDTH-1:0]   score_reg, score_next, score_add;
    logic [SCORE_WIDTH:0]     coin_sum;
    logic [2:0]               lives_reg, lives_next;
    logic [INV_W-1:0]         inv_reg, inv_next;
    logic [NUM_COIN_CH-1:0]   coin_pend_reg, coin_pend_next, coin_take;
    logic [NUM_HAZ_CH-1:0]    haz_pend_reg, haz_pend_next, haz_take;
    logic                     btn_l_reg, btn_l_next, btn_r_reg, btn_r_next;
    logic                     spawn_reg, spawn_next, over_reg, over_next;
    logic                     press_l, press_r, restart;

    function automatic logic [SCORE_WIDTH:0] popcnt(input logic [NUM_COIN_CH-1:0] v);
        popcnt = '0;
        for (int i = 0; i < NUM_COIN_CH; i++)
            popcnt = popcnt + (SCORE_WIDTH + 1)'(v[i]);
    endfunction

    // Sticky hit latches: the set consumed on a tick is latched OR live input.
    generate
        for (genvar gi = 0; gi < NUM_COIN_CH; gi++) begin : g_coin
            assign coin_take[gi]      = coin_pend_reg[gi] | coin_hit[gi];
            assign coin_pend_next[gi] = frame_tick ? 1'b0 : coin_take[gi];
        end
        for (genvar gi = 0; gi < NUM_HAZ_CH; gi++) begin : g_haz
            assign haz_take[gi]      = haz_pend_reg[gi] | haz_hit[gi];
            assign haz_pend_next[gi] = frame_tick ? 1'b0 : haz_take[gi];
        end
    endgenerate

    // Next-state and datapath decisions, evaluated once per frame tick.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        logo_next  = logo_reg;
        pv_next    = pv_reg;
        lane_next  = lane_reg;
        score_next = score_reg;
        lives_next = lives_reg;
        inv_next   = inv_reg;
        btn_l_next = btn_l_reg;
        btn_r_next = btn_r_reg;
        restart    = 1'b0;

        press_l = btn_left & ~btn_l_reg;
        press_r = btn_right & ~btn_r_reg;

        coin_sum  = {1'b0, score_reg} + popcnt(coin_take);
        score_add = coin_sum[SCORE_WIDTH] ? '1 : coin_sum[SCORE_WIDTH-1:0];

        // Simultaneous presses cancel; lane saturates at both edges.
        lane_mv = lane_reg;
        if (press_l && !press_r && lane_reg != '0)
            lane_mv = lane_reg - LANE_W'(1);
        else if (press_r && !press_l && lane_reg != LANE_MAX)
            lane_mv = lane_reg + LANE_W'(1);

        if (frame_tick) begin
            btn_l_next = btn_left;
            btn_r_next = btn_right;
            case (state_reg)
                ST_COUNT: begin
                    if (cnt_reg != '0) cnt_next = cnt_reg - CNT_W'(1);
                    else               state_next = ST_LOGO;
                end
                ST_LOGO: begin
                    if (logo_reg < LOGO_END_W) logo_next = logo_reg + LOGO_STP_W;
                    else                       state_next = ST_INTRO;
                end
                ST_INTRO: begin
                    if (pv_reg > PL_END_W) pv_next = pv_reg - PL_STEP_W;
                    else                   state_next = ST_PLAY;
                end
                ST_PLAY: begin
                    score_next = score_add;
                    lane_next  = lane_mv;
                    if (|haz_take) begin
                        if (lives_reg <= 3'd1) begin
                            lives_next = 3'd0;
                            state_next = ST_OVER;
                        end else begin
                            lives_next = lives_reg - 3'd1;
                            inv_next   = INV_W'(INVULN_FRAMES);
                            state_next = ST_HIT;
                        end
                    end
                end
                ST_HIT: begin
                    score_next = score_add;
                    lane_next  = lane_mv;
                    if (inv_reg <= INV_W'(1)) begin
                        inv_next   = '0;
                        state_next = ST_PLAY;
                    end else begin
                        inv_next = inv_reg - INV_W'(1);
                    end
                end
                ST_OVER: restart = press_l | press_r;
                default: restart = 1'b1;
            endcase
            if (restart) begin
                state_next = ST_COUNT;
                cnt_next   = CNT_W'(COUNTDOWN);
                score_next = '0;
                lives_next = 3'(LIVES);
                logo_next  = '0;
                pv_next    = PL_START_W;
                lane_next  = LANE_MID;
            end
        end

        hoff_next  = (12'(lane_next) - 12'(NUM_LANES / 2)) * 12'(LANE_PITCH);
        spawn_next = (state_next == ST_PLAY) || (state_next == ST_HIT);
        over_next  = (state_next == ST_OVER);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_COUNT;
            cnt_reg       <= CNT_W'(COUNTDOWN);
            logo_reg      <= '0;
            pv_reg        <= PL_START_W;
            hoff_reg      <= '0;
            lane_reg      <= LANE_MID;
            score_reg     <= '0;
            lives_reg     <= 3'(LIVES);
            inv_reg       <= '0;
            coin_pend_reg <= '0;
            haz_pend_reg  <= '0;
            btn_l_reg     <= 1'b0;
            btn_r_reg     <= 1'b0;
            spawn_reg     <= 1'b0;
            over_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            logo_reg      <= logo_next;
            pv_reg        <= pv_next;
            hoff_reg      <= hoff_next;
            lane_reg      <= lane_next;
            score_reg     <= score_next;
            lives_reg     <= lives_next;
            inv_reg       <= inv_next;
            coin_pend_reg <= coin_pend_next;
            haz_pend_reg  <= haz_pend_next;
            btn_l_reg     <= btn_l_next;
            btn_r_reg     <= btn_r_next;
            spawn_reg     <= spawn_next;
            over_reg      <= over_next;
        end
    end

    assign state          = state_reg;
    assign logo_voffset   = logo_reg;
    assign player_voffset = pv_reg;
    assign player_hoffset = hoff_reg;
    assign player_lane    = lane_reg;
    assign score          = score_reg;
    assign lives          = lives_reg;
    assign spawn_en       = spawn_reg;
    assign game_over      = over_reg;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Bench for game_flow_ctrl: frame-level behavioural model compared every
// cycle, plus literal checkpoints along a directed game scenario.
module tb_game_flow_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        frame_tick = 1'b0;
    logic        btn_left = 1'b0;
    logic        btn_right = 1'b0;
    logic [2:0]  coin_hit = '0;
    logic [3:0]  haz_hit = '0;

    logic [2:0]  state, state4;
    logic [11:0] logo_voffset, player_voffset, player_hoffset;
    logic [11:0] logo4, pv4, hoff4;
    logic [1:0]  player_lane, lane4;
    logic [15:0] score;
    logic [3:0]  score4;
    logic [2:0]  lives, lives4;
    logic        spawn_en, game_over, spawn4, over4;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    game_flow_ctrl dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick),
        .btn_left(btn_left), .btn_right(btn_right),
        .coin_hit(coin_hit), .haz_hit(haz_hit),
        .state(state), .logo_voffset(logo_voffset),
        .player_voffset(player_voffset), .player_hoffset(player_hoffset),
        .player_lane(player_lane), .score(score), .lives(lives),
        .spawn_en(spawn_en), .game_over(game_over)
    );

    game_flow_ctrl #(.SCORE_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .frame_tick(frame_tick),
        .btn_left(btn_left), .btn_right(btn_right),
        .coin_hit(coin_hit), .haz_hit(haz_hit),
        .state(state4), .logo_voffset(logo4),
        .player_voffset(pv4), .player_hoffset(hoff4),
        .player_lane(lane4), .score(score4), .lives(lives4),
        .spawn_en(spawn4), .game_over(over4)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model (frame level) ----------------
    int m_state, m_cnt, m_logo, m_pv, m_lane, m_score, m_score4, m_lives, m_inv;
    bit [2:0] m_pc;
    bit [3:0] m_ph;
    bit m_bl, m_br;

    task automatic model_restart();
        m_state = 0; m_cnt = 5; m_score = 0; m_score4 = 0; m_lives = 3;
        m_logo = 0; m_pv = 180; m_lane = 1;
    endtask

    task automatic model_step();
        bit [2:0] c;
        bit [3:0] h;
        bit pl, pr;
        int pc;
        if (rst) begin
            model_restart();
            m_pc = '0; m_ph = '0; m_bl = 0; m_br = 0; m_inv = 0;
        end else begin
            c = m_pc | coin_hit;
            h = m_ph | haz_hit;
            if (!frame_tick) begin
                m_pc = c; m_ph = h;
            end else begin
                m_pc = '0; m_ph = '0;
                pl = btn_left && !m_bl;
                pr = btn_right && !m_br;
                m_bl = btn_left; m_br = btn_right;
                pc = $countones(c);
                if (m_state == 3 || m_state == 4) begin
                    m_score  = (m_score + pc > 65535) ? 65535 : m_score + pc;
                    m_score4 = (m_score4 + pc > 15) ? 15 : m_score4 + pc;
                    if (pl && !pr && m_lane > 0) m_lane--;
                    if (pr && !pl && m_lane < 2) m_lane++;
                end
                case (m_state)
                    0: if (m_cnt > 0) m_cnt--; else m_state = 1;
                    1: if (m_logo < 640) m_logo += 30; else m_state = 2;
                    2: if (m_pv > 50) m_pv -= 20; else m_state = 3;
                    3: if (h != 0) begin
                        if (m_lives == 1) begin m_lives = 0; m_state = 5; end
                        else begin m_lives--; m_inv = 60; m_state = 4; end
                    end
                    4: begin m_inv--; if (m_inv == 0) m_state = 3; end
                    5: if (pl || pr) model_restart();
                    default: model_restart();
                endcase
            end
        end
    endtask

    always @(posedge clk) model_step();

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("state", int'(state), m_state);
            chk("logo_voffset", int'($signed(logo_voffset)), m_logo);
            chk("player_voffset", int'($signed(player_voffset)), m_pv);
            chk("player_hoffset", int'($signed(player_hoffset)), (m_lane - 1) * 100);
            chk("player_lane", int'(player_lane), m_lane);
            chk("score", int'(score), m_score);
            chk("score_w4", int'(score4), m_score4);
            chk("lives", int'(lives), m_lives);
            chk("spawn_en", int'(spawn_en), int'(m_state == 3 || m_state == 4));
            chk("game_over", int'(game_over), int'(m_state == 5));
        end
    end

    // ---------------- stimulus helpers (start and end on negedge) ----------------
    task automatic tick();
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse(input logic [2:0] c, input logic [3:0] h);
        coin_hit = c; haz_hit = h;
        @(negedge clk);
        coin_hit = '0; haz_hit = '0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_state"}, int'(state), 0);
        chk({tag, "_score"}, int'(score), 0);
        chk({tag, "_lives"}, int'(lives), 3);
        chk({tag, "_logo"}, int'(logo_voffset), 0);
        chk({tag, "_pv"}, int'(player_voffset), 180);
        chk({tag, "_hoff"}, int'(player_hoffset), 0);
        chk({tag, "_lane"}, int'(player_lane), 1);
        chk({tag, "_spawn"}, int'(spawn_en), 0);
        chk({tag, "_over"}, int'(game_over), 0);
    endtask

    initial begin
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        check_reset_values("reset");

        // Start-up sequence timing.
        ticks(6);
        chk("tick6_state", int'(state), 1);
        ticks(23);
        chk("tick29_state", int'(state), 2);
        chk("tick29_logo", int'(logo_voffset), 660);
        ticks(8);
        chk("tick37_state", int'(state), 3);
        chk("tick37_pv", int'(player_voffset), 40);
        chk("tick37_spawn", int'(spawn_en), 1);

        // Coin scoring and saturation in the narrow-score instance.
        pulse(3'b111, 4'b0000);
        tick();
        chk("coin_score", int'(score), 3);
        for (int i = 0; i < 5; i++) begin
            pulse(3'b111, 4'b0000);
            tick();
        end
        chk("coin_score6", int'(score), 18);
        chk("coin_score_sat", int'(score4), 15);

        // Lane movement.
        btn_right = 1'b1; tick();
        chk("right_lane", int'(player_lane), 2);
        chk("right_hoff", int'($signed(player_hoffset)), 100);
        btn_right = 1'b0; tick();
        btn_right = 1'b1; tick();
        chk("right_sat_lane", int'(player_lane), 2);
        btn_right = 1'b0; tick();
        btn_left = 1'b1; ticks(3);
        chk("left_held_lane", int'(player_lane), 1);
        btn_left = 1'b0; tick();
        btn_left = 1'b1; btn_right = 1'b1; tick();
        chk("both_lane", int'(player_lane), 1);
        btn_left = 1'b0; btn_right = 1'b0; tick();

        // Hazard, invulnerability window with extra hazards and coins.
        pulse(3'b000, 4'b0100);
        tick();
        chk("hit_state", int'(state), 4);
        chk("hit_lives", int'(lives), 2);
        for (int i = 1; i <= 59; i++) begin
            if (i % 10 == 5) pulse(3'b010, 4'b1111);
            tick();
        end
        chk("hit59_state", int'(state), 4);
        chk("hit59_lives", int'(lives), 2);
        tick();
        chk("hit60_state", int'(state), 3);

        pulse(3'b000, 4'b0001);
        tick();
        chk("hit2_lives", int'(lives), 1);
        ticks(60);
        pulse(3'b001, 4'b1000);
        tick();
        chk("over_state", int'(state), 5);
        chk("over_lives", int'(lives), 0);
        chk("over_flag", int'(game_over), 1);

        // OVER holds score against hits, then restarts on a press.
        pulse(3'b111, 4'b1111);
        tick();
        chk("over_hold_state", int'(state), 5);
        btn_left = 1'b1; tick();
        chk("restart_state", int'(state), 0);
        chk("restart_score", int'(score), 0);
        chk("restart_lives", int'(lives), 3);
        btn_left = 1'b0;

        // Back to PLAY, score, hit, then reset in HIT.
        ticks(37);
        pulse(3'b101, 4'b0000);
        tick();
        pulse(3'b000, 4'b0010);
        tick();
        chk("hit_again_state", int'(state), 4);
        ticks(3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_values("hit_rst");
        ticks(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/game_flow_ctrl.md
GAME_FLOW_CTRL -- requirements
Module: game_flow_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- NUM_LANES, 3, player lane count (>=2)
- LANE_PITCH, 100, signed horizontal pixel spacing between lanes
- NUM_COIN_CH, 3, coin collision channels
- NUM_HAZ_CH, 4, hazard collision channels
- SCORE_WIDTH, 16, score width
- LIVES, 3, lives per game (1..7)
- INVULN_FRAMES, 60, post-hit invulnerability frames
- COUNTDOWN, 5, pre-game countdown start
- LOGO_STEP, 30; LOGO_END, 640: logo scroll step and end
- PLAYER_START, 180; PLAYER_END, 50; PLAYER_STEP, 20: player slide-in start, end and step
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, single clock for all logic
- rst, in, 1, synchronous, active-high reset
- frame_tick, in, 1, one-cycle pulse per video frame
- btn_left, btn_right, in, 1 each, level buttons, synchronous to clk
- coin_hit, in, NUM_COIN_CH, per-channel single-cycle hit pulses
- haz_hit, in, NUM_HAZ_CH, per-channel single-cycle hit pulses
- state, out, 3, COUNT=0, LOGO=1, INTRO=2, PLAY=3, HIT=4, OVER=5
- logo_voffset, player_voffset, player_hoffset, out, 12 each, signed layer offsets
- player_lane, out, clog2(NUM_LANES), current lane
- score, out, SCORE_WIDTH, coins collected
- lives, out, 3, remaining lives
- spawn_en, out, 1, high in PLAY or HIT
- game_over, out, 1, high in OVER

Function
REQ-003 All outputs are registered; state, offsets, lane, score, lives and counters change only on clk edges with frame_tick=1.
REQ-004 Each coin_hit/haz_hit bit sets a sticky pending bit on any cycle. On a frame_tick cycle the consumed set is pending OR current input; pending then clears.
REQ-005 Button edges: btn levels are sampled on each frame_tick. A press is current sample=1 with previous sample=0.
REQ-006 COUNT: countdown>0 decrements by 1. At 0, go to LOGO.
REQ-007 LOGO: logo_voffset<LOGO_END adds LOGO_STEP. Otherwise go to INTRO.
REQ-008 INTRO: player_voffset>PLAYER_END subtracts PLAYER_STEP. Otherwise go to PLAY.
REQ-009 PLAY: score adds popcount of consumed coins, saturating at 2^SCORE_WIDTH-1.
- Any consumed hazard decrements lives.
- If lives was 1, go to OVER with lives=0.
- Otherwise go to HIT with invuln counter=INVULN_FRAMES.
REQ-010 HIT: coins are scored as in PLAY and hazards are discarded. The counter decrements each frame; when it reaches 0, go to PLAY.
REQ-011 Lane moves are allowed in PLAY and HIT only:
- left press decrements lane, saturating at 0
- right press increments lane, saturating at NUM_LANES-1
- simultaneous presses give no move
REQ-012 player_hoffset = (player_lane - NUM_LANES/2) * LANE_PITCH, 12-bit two's complement, updated in the same cycle as the lane.
REQ-013 OVER: score, lane and offsets hold and hits are discarded. A press of either button restarts the game:
- state = COUNT, countdown = COUNTDOWN, score = 0, lives = LIVES
- logo_voffset = 0, player_voffset = PLAYER_START, lane = NUM_LANES/2
REQ-014 Coin and hazard consumed in the same PLAY frame: the coin is scored and the hazard is processed in that frame.
REQ-015 Encodings 6 and 7 are illegal and return to COUNT on the next frame_tick with full restart values (REQ-013).

Reset
REQ-016 rst=1 sets the following on the next clk edge, with priority over frame_tick and all hit inputs:
- state = COUNT, countdown = COUNTDOWN, score = 0, lives = LIVES
- logo_voffset = 0, player_voffset = PLAYER_START, player_hoffset = 0, player_lane = NUM_LANES/2
- pending bits and sampled buttons cleared
- spawn_en = 0, game_over = 0
REQ-017 rst asserted mid-game (including HIT or OVER) behaves identically to reset at power-up.

Verification
REQ-018 Defaults, reset, then frame_tick only. Required response:
- state=LOGO after tick 6
- INTRO after tick 29, with logo_voffset=660
- PLAY after tick 37, with player_voffset=40 and spawn_en=1
REQ-019 In PLAY, coin_hit=3'b111 pulsed mid-frame, then a tick -> score=3. Repeated with SCORE_WIDTH=4 for 6 frames -> score=15 (saturated).
REQ-020 In PLAY, lane=1:
- right press -> lane=2, hoffset=100
- second right press -> lane stays 2
- left held 3 frames -> lane=1 (one move only)
- both pressed -> no move
REQ-021 In PLAY, haz_hit[2] pulsed -> state=HIT and lives=2.
- Further hazards during the 60 frames leave lives=2.
- On frame 60 -> PLAY.
- Two more hits -> OVER, lives=0, game_over=1.
REQ-022 In OVER, btn_left press -> COUNT, score=0, lives=3. In HIT, rst for one cycle -> all REQ-016 values.
